// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Brief    : Shared definitions for the division datapath and its control FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 8;

  localparam int CTL_LOAD  = 0;
  localparam int CTL_SHL   = 1;
  localparam int CTL_SUB   = 2;
  localparam int CTL_ADD   = 3;
  localparam int CTL_SHR   = 4;
  localparam int CTL_CAP_N = 5;
  localparam int CTL_EN    = 6;
  localparam int CTL_W     = 7;

  typedef logic [CTL_W-1:0] ctl_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LOAD = 3'd1,
    OP_SUB  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5
  } op_e;

  // Single arithmetic op per cycle: LOAD > SUB > ADD > SHL > SHR.
  function automatic op_e decode_op(input ctl_t c);
    if (c[CTL_LOAD]) return OP_LOAD;
    if (c[CTL_SUB])  return OP_SUB;
    if (c[CTL_ADD])  return OP_ADD;
    if (c[CTL_SHL])  return OP_SHL;
    if (c[CTL_SHR])  return OP_SHR;
    return OP_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_datapath_if.sv
// ============================================================================
// Module   : div_datapath_if
// Brief    : Control strobes, operands and status/result bus of div_datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_datapath_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);
  import div_pkg::*;

  ctl_t             ctl;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] k_o;
  logic [WIDTH-1:0] w_o;
  logic             e_o;
  logic             ge2k_o;
  logic             wone_o;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             valid_o;
  logic             err_o;

  modport master (
    output ctl, dividend, divisor,
    input  a_o, k_o, w_o, e_o, ge2k_o, wone_o, quotient, remainder, valid_o, err_o
  );

  modport slave (
    input  ctl, dividend, divisor,
    output a_o, k_o, w_o, e_o, ge2k_o, wone_o, quotient, remainder, valid_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/div_addsub.sv
// ============================================================================
// Module   : div_addsub
// Brief    : WIDTH+1-bit add/subtract with borrow out, plus A >= 2*K compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_result,
  output logic             o_borrow,
  output logic             o_ge2k
);

  logic [WIDTH:0] w_full;

  always_comb begin
    if (i_sub) begin
      w_full = {1'b0, i_a} - {1'b0, i_b};
    end else begin
      w_full = {1'b0, i_a} + {1'b0, i_b};
    end
    o_result = w_full[WIDTH-1:0];
    o_borrow = i_sub & w_full[WIDTH];
    // 2*K is formed by widening K one bit, so it never overflows.
    o_ge2k   = ({1'b0, i_a} >= {i_b, 1'b0});
  end

endmodule

`default_nettype wire

// File: rtl/div_datapath.sv
// ============================================================================
// Module   : div_datapath
// Brief    : Restoring-division datapath (A, K, W, Q, E) executing FSM strobes.
//            Optional DP_DIVZERO_GUARD_EN adds a sticky divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  div_datapath_if.slave bus
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] r_q;
  logic             r_e;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_valid;

  op_e              w_op;
  logic             w_cap;
  logic             w_shl_ok;
  logic             w_blocked;
  logic [WIDTH-1:0] w_sum;
  logic             w_borrow;
  logic             w_ge2k;
  logic [WIDTH-1:0] w_cap_q;

  always_comb begin
    w_op     = bus.ctl[CTL_EN] ? decode_op(bus.ctl) : OP_NONE;
    w_cap    = bus.ctl[CTL_EN] & ~bus.ctl[CTL_CAP_N];
    w_shl_ok = ~r_k[WIDTH-1] & ~r_w[WIDTH-1];
  end

  div_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_a      (r_a),
    .i_b      (r_k),
    .i_sub    (w_op != OP_ADD),
    .o_result (w_sum),
    .o_borrow (w_borrow),
    .o_ge2k   (w_ge2k)
  );

`ifdef DP_DIVZERO_GUARD_EN
  logic r_err;

  // Sticky until a LOAD brings a nonzero divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_op == OP_LOAD) begin
      r_err <= (bus.divisor == '0);
    end
  end

  assign w_blocked  = r_err;
  assign w_cap_q    = r_err ? '1 : r_q;
  assign bus.err_o  = r_err;
`else
  assign w_blocked  = 1'b0;
  assign w_cap_q    = r_q;
  assign bus.err_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_k <= '0;
      r_w <= '0;
      r_q <= '0;
      r_e <= 1'b0;
    end else begin
      case (w_op)
        OP_LOAD: begin
          r_a <= bus.dividend;
          r_k <= bus.divisor;
          r_w <= c_one;
          r_q <= '0;
          r_e <= 1'b0;
        end
        OP_SUB: begin
          if (!w_blocked) begin
            // A keeps the wrapped difference on borrow; ADD restores it later.
            r_a <= w_sum;
            r_e <= ~w_borrow;
            if (!w_borrow) begin
              r_q <= r_q | r_w;
            end
          end
        end
        OP_ADD: begin
          if (!w_blocked) begin
            r_a <= w_sum;
          end
        end
        OP_SHL: begin
          if (!w_blocked && w_shl_ok) begin
            r_k <= r_k << 1;
            r_w <= r_w << 1;
          end
        end
        OP_SHR: begin
          if (!w_blocked) begin
            r_k <= r_k >> 1;
            r_w <= r_w >> 1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Capture samples pre-edge Q/A, independent of the op in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_cap;
      if (w_cap) begin
        r_quo <= w_cap_q;
        r_rem <= r_a;
      end
    end
  end

  assign bus.a_o       = r_a;
  assign bus.k_o       = r_k;
  assign bus.w_o       = r_w;
  assign bus.e_o       = r_e;
  assign bus.ge2k_o    = w_ge2k;
  assign bus.wone_o    = (r_w == c_one);
  assign bus.quotient  = r_quo;
  assign bus.remainder = r_rem;
  assign bus.valid_o   = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_div_datapath.sv
// ============================================================================
// Module   : tb_div_datapath
// Brief    : Self-checking bench for div_datapath: directed plan plus random
//            strobes against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_datapath;
  import div_pkg::*;

  localparam int W = 8;

  localparam ctl_t C_IDLE = 7'h60;
  localparam ctl_t C_LOAD = 7'h61;
  localparam ctl_t C_SHL  = 7'h62;
  localparam ctl_t C_SUB  = 7'h64;
  localparam ctl_t C_ADD  = 7'h68;
  localparam ctl_t C_SHR  = 7'h70;
  localparam ctl_t C_CAP  = 7'h40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_en = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int ma, mk, mw, mq, mquo, mrem;
  bit me, mvalid, merr;

  always #5 clk = ~clk;

  div_datapath_if #(.WIDTH(W)) bus ();

  div_datapath #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ma = 0; mk = 0; mw = 0; mq = 0; mquo = 0; mrem = 0;
    me = 0; mvalid = 0; merr = 0;
  endtask

  // One clock of the datapath in plain integer arithmetic.
  task automatic model_step(input ctl_t c, input int dd, input int dv);
    bit cap;
    int nquo, nrem;
    if (!c[6]) begin
      mvalid = 0;
      return;
    end
    cap  = !c[5];
    nquo = merr ? 255 : mq;
    nrem = ma;
    if (c[0]) begin
      ma = dd; mk = dv; mw = 1; mq = 0; me = 0;
`ifdef DP_DIVZERO_GUARD_EN
      merr = (dv == 0);
`endif
    end else if (!merr) begin
      if (c[2]) begin
        if (ma >= mk) begin
          ma = ma - mk; me = 1; mq = mq | mw;
        end else begin
          ma = ma - mk + 256; me = 0;
        end
      end else if (c[3]) begin
        ma = (ma + mk) % 256;
      end else if (c[1]) begin
        if (mk < 128 && mw < 128) begin
          mk = mk * 2; mw = mw * 2;
        end
      end else if (c[4]) begin
        mk = mk / 2; mw = mw / 2;
      end
    end
    if (cap) begin
      mquo = nquo; mrem = nrem;
    end
    mvalid = cap;
  endtask

  task automatic step(input ctl_t c, input int dd, input int dv);
    bus.ctl      = c;
    bus.dividend = dd[W-1:0];
    bus.divisor  = dv[W-1:0];
    @(posedge clk);
    model_step(c, dd, dv);
    #1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("a_o",       int'(bus.a_o),       ma);
      chk("k_o",       int'(bus.k_o),       mk);
      chk("w_o",       int'(bus.w_o),       mw);
      chk("e_o",       int'(bus.e_o),       int'(me));
      chk("ge2k_o",    int'(bus.ge2k_o),    (ma >= 2 * mk) ? 1 : 0);
      chk("wone_o",    int'(bus.wone_o),    (mw == 1) ? 1 : 0);
      chk("quotient",  int'(bus.quotient),  mquo);
      chk("remainder", int'(bus.remainder), mrem);
      chk("valid_o",   int'(bus.valid_o),   int'(mvalid));
      chk("err_o",     int'(bus.err_o),     int'(merr));
    end
  end

  initial begin
    bus.ctl      = '0;
    bus.dividend = '0;
    bus.divisor  = '0;
    model_reset();
    #2;
    chk("rst a_o",    int'(bus.a_o),    0);
    chk("rst ge2k_o", int'(bus.ge2k_o), 1);
    chk("rst wone_o", int'(bus.wone_o), 0);
    chk("rst valid",  int'(bus.valid_o), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // 100 / 7
    step(C_LOAD, 100, 7);
    chk("ld a", int'(bus.a_o), 100);
    repeat (3) step(C_SHL, 0, 0);
    chk("shl k", int'(bus.k_o), 56);
    chk("shl w", int'(bus.w_o), 8);
    chk("shl ge2k", int'(bus.ge2k_o), 0);
    step(C_SUB, 0, 0);
    chk("sub1 a", int'(bus.a_o), 44);
    step(C_SHR, 0, 0);
    step(C_SUB, 0, 0);
    chk("sub2 a", int'(bus.a_o), 16);
    step(C_SHR, 0, 0);
    step(C_SUB, 0, 0);
    chk("sub3 a", int'(bus.a_o), 2);
    step(C_SHR, 0, 0);
    chk("shr k", int'(bus.k_o), 7);
    chk("shr wone", int'(bus.wone_o), 1);
    step(C_SUB, 0, 0);
    chk("borrow a", int'(bus.a_o), 251);
    chk("borrow e", int'(bus.e_o), 0);
    step(C_ADD, 0, 0);
    chk("add a", int'(bus.a_o), 2);
    step(C_CAP, 0, 0);
    chk("cap quot", int'(bus.quotient), 14);
    chk("cap rem", int'(bus.remainder), 2);
    chk("cap valid", int'(bus.valid_o), 1);
    step(C_IDLE, 0, 0);
    chk("valid drop", int'(bus.valid_o), 0);

    // SHL blocked by K MSB
    step(C_LOAD, 5, 8'h90);
    step(C_SHL, 0, 0);
    chk("shl blk k", int'(bus.k_o), 8'h90);
    chk("shl blk w", int'(bus.w_o), 1);

    // LOAD wins over SUB
    step(C_SUB, 0, 0);
    step(C_LOAD | C_SUB, 77, 3);
    chk("ld+sub a", int'(bus.a_o), 77);
    chk("ld+sub e", int'(bus.e_o), 0);
    step(C_CAP, 0, 0);
    chk("ld+sub q", int'(bus.quotient), 0);

    // EN low: SUB + capture ignored
    repeat (3) begin
      step(7'h04, 0, 0);
      chk("en0 a", int'(bus.a_o), 77);
      chk("en0 valid", int'(bus.valid_o), 0);
    end

    // Asynchronous reset mid-division
    step(C_LOAD, 100, 7);
    step(C_SHL, 0, 0);
    step(C_SUB, 0, 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst a", int'(bus.a_o), 0);
    chk("arst k", int'(bus.k_o), 0);
    chk("arst ge2k", int'(bus.ge2k_o), 1);
    chk("arst quot", int'(bus.quotient), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(C_LOAD, 100, 7);
    chk("post-rst a", int'(bus.a_o), 100);
    chk("post-rst w", int'(bus.w_o), 1);

    // Zero divisor
    step(C_LOAD, 50, 0);
`ifdef DP_DIVZERO_GUARD_EN
    chk("dz err", int'(bus.err_o), 1);
    step(C_SUB, 0, 0);
    step(C_CAP, 0, 0);
    chk("dz quot", int'(bus.quotient), 255);
    chk("dz rem", int'(bus.remainder), 50);
    chk("dz valid", int'(bus.valid_o), 1);
    step(C_LOAD, 50, 5);
    chk("dz clr", int'(bus.err_o), 0);
`else
    chk("dz err", int'(bus.err_o), 0);
    step(C_SUB, 0, 0);
    chk("dz sub a", int'(bus.a_o), 50);
    chk("dz sub e", int'(bus.e_o), 1);
`endif

    // Randomized strobes
    for (int i = 0; i < 3000; i++) begin
      ctl_t c;
      int   dv;
      c    = ctl_t'($urandom);
      c[6] = ($urandom_range(0, 9) != 0);
      c[5] = ($urandom_range(0, 4) != 0);
      c[0] = ($urandom_range(0, 19) == 0);
      dv   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
      step(c, int'($urandom_range(0, 255)), dv);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
